// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// Module      : imem_loader
// Description : Write-side loader for the instruction memory. Receives a
//               byte stream (16-bit little-endian word count, then
//               little-endian 32-bit words) over a valid/ready port, writes
//               each assembled word through the memory write port, and holds
//               the CPU while the load is in progress.
//               Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing
//               checksum byte that must bring the 8-bit data-byte sum to 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       c_depth     = 32'd1 << ADDR_W;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_len;
  logic [15:0]         r_wcount;
  logic [1:0]          r_bidx;
  logic [31:0]         r_word;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_err;
  logic                w_xfer;
  logic [15:0]         w_len_full;
  logic                w_len_bad;
  logic                w_last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
  logic [7:0]          w_csum_sum;
  assign w_csum_sum = r_csum + rx_data;
`endif

  assign w_xfer      = rx_valid & rx_ready;
  // Full length as it will look once the high byte is captured.
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_len_bad   = {16'd0, w_len_full} > c_depth;
  assign w_last_word = (r_wcount + 16'd1) == r_len;

  assign mem_addr  = r_addr;
  assign mem_wdata = r_word;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    cpu_hold = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_DONE;
`endif
          end else if (w_len_bad) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (r_bidx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = (w_csum_sum == 8'd0) ? S_DONE : S_IDLE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte assembly, word/address counters, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len    <= 16'd0;
      r_wcount <= 16'd0;
      r_bidx   <= 2'd0;
      r_word   <= 32'd0;
      r_addr   <= '0;
      r_err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum   <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= 16'd0;
            r_wcount <= 16'd0;
            r_bidx   <= 2'd0;
            r_addr   <= c_base_addr;
            r_err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum   <= 8'd0;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_xfer) r_len[7:0] <= rx_data;
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= rx_data;
            if (w_len_bad) r_err <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word[{r_bidx, 3'b000} +: 8] <= rx_data;
            r_bidx <= r_bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= w_csum_sum;
`endif
          end
        end
        S_WRITE: begin
          r_wcount <= r_wcount + 16'd1;
          r_addr   <= r_addr + 1'b1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer && (w_csum_sum != 8'd0)) r_err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Random byte streams are
//               driven with random valid gaps; expected writes, done and err
//               come from a stream-level model of the load protocol.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  localparam int c_addr_w = 10;
  localparam int c_base   = 1023;
  localparam int c_depth  = 1 << c_addr_w;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                mem_we;
  logic [c_addr_w-1:0] mem_addr;
  logic [31:0]         mem_wdata;
  logic                cpu_hold;
  logic                busy;
  logic                done;
  logic                err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [c_addr_w-1:0] wq_addr[$];
  logic [31:0]         wq_data[$];
  logic [7:0]          bq[$];

  imem_loader #(.ADDR_W(c_addr_w), .BASE_ADDR(c_base)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every memory write and done cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves time at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte, wait for the handshake, then idle for a random gap.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 50) begin
        check("rx_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  // One complete load of len words from bq, checked against the model.
  task automatic run_load(input logic [15:0] len, input int gapmax, input bit poke, input bit bad_csum);
    logic [7:0] sum;
    logic [7:0] cbyte;
    bit         exp_done;
    bit         exp_err;
    int         exp_nw;
    int         n;
    logic [31:0] w;
    sum = 8'd0;
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
    pulse_start();
    check("hold_on", {31'd0, cpu_hold}, 32'd1);
    check("busy_on", {31'd0, busy}, 32'd1);
    check("err_clr", {31'd0, err}, 32'd0);
    send_byte(len[7:0], gapmax);
    send_byte(len[15:8], gapmax);
    exp_err  = (int'(len) > c_depth);
    exp_done = 1'b0;
    exp_nw   = 0;
    if (!exp_err) begin
      exp_nw = int'(len);
      for (int i = 0; i < int'(len) * 4; i++) begin
        send_byte(bq[i], gapmax);
        sum += bq[i];
        if (poke && i == 1) pulse_start();
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      cbyte = 8'd0 - sum;
      if (bad_csum) cbyte = cbyte ^ 8'h01;
      send_byte(cbyte, gapmax);
      exp_done = !bad_csum;
      exp_err  = bad_csum;
`else
      cbyte    = 8'd0;
      exp_done = 1'b1;
`endif
    end
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    check("nwrites", wq_addr.size(), exp_nw);
    for (int i = 0; i < exp_nw && i < wq_addr.size(); i++) begin
      w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      check("waddr", {22'd0, wq_addr[i]}, (c_base + i) % c_depth);
      check("wdata", wq_data[i], w);
    end
    check("done_cnt", done_cnt, {31'd0, exp_done});
    check("err_end", {31'd0, err}, {31'd0, exp_err});
    check("hold_off", {31'd0, cpu_hold}, 32'd0);
    check("ready_off", {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: two-word stream, no gaps, then the same with 3-cycle gaps.
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(16'd2, 0, 1'b0, 1'b0);
    run_load(16'd2, 3, 1'b0, 1'b0);

    // Length one past the memory depth, then zero length.
    run_load(16'h0401, 0, 1'b0, 1'b0);
    run_load(16'd0, 1, 1'b0, 1'b0);

    // Reset together with start: reset wins.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a word, then a clean one-word load.
    fill_bytes(8);
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    send_byte(bq[0], 0);
    send_byte(bq[1], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    check("midrst_nowrite", wq_addr.size(), 32'd0);
    fill_bytes(4);
    run_load(16'd1, 2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(16'd1, 0, 1'b0, 1'b0);
    run_load(16'd1, 0, 1'b0, 1'b1);
`endif

    // Full-depth load: every address written once, wrapping from the base.
    fill_bytes(4 * c_depth);
    run_load(16'(c_depth), 0, 1'b0, 1'b0);

    // Randomized loads with gaps, ignored start pulses and oversize lengths.
    for (int t = 0; t < 25; t++) begin
      logic [15:0] len;
      if ($urandom_range(0, 7) == 0) len = 16'($urandom_range(c_depth + 1, 65535));
      else                           len = 16'($urandom_range(1, 8));
      fill_bytes((int'(len) > c_depth) ? 0 : 4 * int'(len));
      run_load(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
